// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared floating-point format widths and stage-1 payload type
package fp_pkg;
   localparam int SP_EXP_W = 8;
   localparam int SP_MAN_W = 23;
   localparam int DP_EXP_W = 11;
   localparam int DP_MAN_W = 52;
   localparam int GRS_W    = 3;

   // Sized for the widest format; narrower formats occupy the low bits of each field.
   typedef struct packed {
      logic                swap;
      logic [DP_EXP_W-1:0] shift;
      logic [DP_EXP_W-1:0] exp_big;
      logic [DP_MAN_W:0]   sig_big;
      logic [DP_MAN_W:0]   sig_small;
   } s1_payload_t;
endpackage

// File: rtl/sticky_shr.sv
// rtl/sticky_shr.sv - right barrel shift folding every shifted-out bit into the LSB
module sticky_shr #(
   parameter int DATA_W  = 27,
   parameter int SHIFT_W = 8
) (
   input  logic [DATA_W-1:0]  data_in,
   input  logic [SHIFT_W-1:0] shift,
   output logic [DATA_W-1:0]  data_out
);
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] lost_mask;
   logic              lost;

   always_comb begin
      shifted   = data_in >> shift;
      lost_mask = ~({DATA_W{1'b1}} << shift);
      lost      = |(data_in & lost_mask);
      if (32'(shift) >= DATA_W) begin
         data_out = {{(DATA_W-1){1'b0}}, |data_in};
      end else begin
         data_out = {shifted[DATA_W-1:1], shifted[0] | lost};
      end
   end
endmodule

// File: rtl/align_swap_pipe.sv
// rtl/align_swap_pipe.sv - two-stage exponent compare/swap and significand alignment
module align_swap_pipe #(
   parameter int EXP_W = fp_pkg::SP_EXP_W,
   parameter int MAN_W = fp_pkg::SP_MAN_W,
   parameter int GRS_W = fp_pkg::GRS_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [EXP_W-1:0]         exp1,
   input  logic [EXP_W-1:0]         exp2,
   input  logic [MAN_W:0]           sig1,
   input  logic [MAN_W:0]           sig2,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W-1:0]         exp_big,
   output logic [MAN_W:0]           sig_big,
   output logic [MAN_W+GRS_W:0]     sig_small,
   output logic [EXP_W-1:0]         shift,
   output logic                     swap
);
   import fp_pkg::*;

   localparam int SIG_W   = MAN_W + 1;
   localparam int SMALL_W = SIG_W + GRS_W;

   s1_payload_t        s1_new, s1_d, s1_q;
   logic               s1_valid_d, s1_valid_q;
   logic               s2_valid_d, s2_valid_q;
   logic               s2_advance;
   logic [EXP_W:0]     diff;
   logic               borrow;
   logic [EXP_W-1:0]   exp_big_d, exp_big_q, shift_d, shift_q;
   logic [SIG_W-1:0]   sig_big_d, sig_big_q;
   logic [SMALL_W-1:0] sig_small_d, sig_small_q, shr_out;
   logic               swap_d, swap_q;

   // Negating diff also yields shift=0 on an exponent tie, so one swap branch covers both cases.
   always_comb begin
      diff   = {1'b0, exp1} - {1'b0, exp2};
      borrow = diff[EXP_W];
      s1_new = '0;
      if (borrow || (diff == '0 && sig2 > sig1)) begin
         s1_new.swap      = 1'b1;
         s1_new.exp_big   = DP_EXP_W'(exp2);
         s1_new.sig_big   = (DP_MAN_W+1)'(sig2);
         s1_new.sig_small = (DP_MAN_W+1)'(sig1);
         s1_new.shift     = DP_EXP_W'(~diff[EXP_W-1:0] + EXP_W'(1));
      end else begin
         s1_new.swap      = 1'b0;
         s1_new.exp_big   = DP_EXP_W'(exp1);
         s1_new.sig_big   = (DP_MAN_W+1)'(sig1);
         s1_new.sig_small = (DP_MAN_W+1)'(sig2);
         s1_new.shift     = DP_EXP_W'(diff[EXP_W-1:0]);
      end
   end

   sticky_shr #(
      .DATA_W (SMALL_W),
      .SHIFT_W(EXP_W)
   ) u_shr (
      .data_in ({s1_q.sig_small[SIG_W-1:0], {GRS_W{1'b0}}}),
      .shift   (s1_q.shift[EXP_W-1:0]),
      .data_out(shr_out)
   );

   always_comb begin
      s2_advance  = !s2_valid_q || out_ready;
      in_ready    = !s1_valid_q || s2_advance;
      s1_valid_d  = s1_valid_q;
      s1_d        = s1_q;
      s2_valid_d  = s2_valid_q;
      exp_big_d   = exp_big_q;
      sig_big_d   = sig_big_q;
      sig_small_d = sig_small_q;
      shift_d     = shift_q;
      swap_d      = swap_q;
      if (in_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) s1_d = s1_new;
      end
      if (s2_advance) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            exp_big_d   = s1_q.exp_big[EXP_W-1:0];
            sig_big_d   = s1_q.sig_big[SIG_W-1:0];
            sig_small_d = shr_out;
            shift_d     = s1_q.shift[EXP_W-1:0];
            swap_d      = s1_q.swap;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_q        <= '0;
         s2_valid_q  <= 1'b0;
         exp_big_q   <= '0;
         sig_big_q   <= '0;
         sig_small_q <= '0;
         shift_q     <= '0;
         swap_q      <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_q        <= s1_d;
         s2_valid_q  <= s2_valid_d;
         exp_big_q   <= exp_big_d;
         sig_big_q   <= sig_big_d;
         sig_small_q <= sig_small_d;
         shift_q     <= shift_d;
         swap_q      <= swap_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign exp_big   = exp_big_q;
   assign sig_big   = sig_big_q;
   assign sig_small = sig_small_q;
   assign shift     = shift_q;
   assign swap      = swap_q;
endmodule

// File: tb/tb_align_swap_pipe.sv
// tb/tb_align_swap_pipe.sv - directed self-checking bench for align_swap_pipe
module tb_align_swap_pipe;
   logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, swap;
   logic [7:0]  exp1, exp2, exp_big, shift;
   logic [23:0] sig1, sig2, sig_big;
   logic [26:0] sig_small;
   int          errors = 0;
   int          checks = 0;

   typedef struct packed {
      logic [7:0]  e1, e2;
      logic [23:0] s1, s2;
      logic        sw;
      logic [7:0]  sh, eb;
      logic [23:0] sb;
      logic [26:0] ss;
   } vec_t;

   align_swap_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .exp1(exp1), .exp2(exp2), .sig1(sig1), .sig2(sig2),
      .out_valid(out_valid), .out_ready(out_ready), .exp_big(exp_big),
      .sig_big(sig_big), .sig_small(sig_small), .shift(shift), .swap(swap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] e1, input logic [7:0] e2,
                        input logic [23:0] s1, input logic [23:0] s2);
      exp1 = e1; exp2 = e2; sig1 = s1; sig2 = s2; in_valid = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      exp1 = '0; exp2 = '0; sig1 = '0; sig2 = '0;
      repeat (2) tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid got=%0b want=0", out_valid);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready got=%0b want=1", in_ready);
      end
      checks++;
      if ({exp_big, sig_big, sig_small, shift, swap} !== '0) begin
         errors++;
         $display("FAIL reset_data got exp_big=%0d sig_big=%h sig_small=%h shift=%0d swap=%0b want all 0",
                  exp_big, sig_big, sig_small, shift, swap);
      end
   endtask

   task automatic test_direct;
      out_ready = 1'b1;
      drive(8'd130, 8'd128, 24'h800000, 24'hC00000);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL direct_in_ready got=%0b want=1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL direct_latency_early got out_valid=%0b want=0", out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL direct_latency got out_valid=%0b want=1", out_valid);
      end
      checks++;
      if (swap !== 1'b0 || shift !== 8'd2 || exp_big !== 8'd130 || sig_big !== 24'h800000 ||
          sig_small !== 27'h1800000) begin
         errors++;
         $display("FAIL direct_data got swap=%0b shift=%0d exp_big=%0d sig_big=%h sig_small=%h want 0/2/130/800000/1800000",
                  swap, shift, exp_big, sig_big, sig_small);
      end
      tick();
   endtask

   task automatic test_borrow;
      out_ready = 1'b1;
      drive(8'd127, 8'd130, 24'h900000, 24'h800000);
      tick();
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b1 || swap !== 1'b1 || shift !== 8'd3 || exp_big !== 8'd130 ||
          sig_big !== 24'h800000 || sig_small !== 27'h0900000) begin
         errors++;
         $display("FAIL borrow got valid=%0b swap=%0b shift=%0d exp_big=%0d sig_big=%h sig_small=%h want 1/1/3/130/800000/0900000",
                  out_valid, swap, shift, exp_big, sig_big, sig_small);
      end
      tick();
   endtask

   task automatic test_tie_back_to_back;
      out_ready = 1'b1;
      drive(8'd100, 8'd100, 24'h800001, 24'h800002);
      tick();
      drive(8'd100, 8'd100, 24'h800001, 24'h800001);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL tie_in_ready got=%0b want=1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || swap !== 1'b1 || shift !== 8'd0 || exp_big !== 8'd100 ||
          sig_big !== 24'h800002 || sig_small !== 27'h4000008) begin
         errors++;
         $display("FAIL tie_sig2_bigger got valid=%0b swap=%0b shift=%0d exp_big=%0d sig_big=%h sig_small=%h want 1/1/0/100/800002/4000008",
                  out_valid, swap, shift, exp_big, sig_big, sig_small);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || swap !== 1'b0 || shift !== 8'd0 || sig_big !== 24'h800001 ||
          sig_small !== 27'h4000008) begin
         errors++;
         $display("FAIL tie_equal got valid=%0b swap=%0b shift=%0d sig_big=%h sig_small=%h want 1/0/0/800001/4000008",
                  out_valid, swap, shift, sig_big, sig_small);
      end
      tick();
   endtask

   task automatic test_shift_boundaries;
      vec_t v [6];
      v[0] = '{8'd170, 8'd130, 24'h800000, 24'h800001, 1'b0, 8'd40,  8'd170, 24'h800000, 27'h0000001};
      v[1] = '{8'd154, 8'd130, 24'h800000, 24'h800000, 1'b0, 8'd24,  8'd154, 24'h800000, 27'h0000004};
      v[2] = '{8'd157, 8'd130, 24'h800000, 24'h800000, 1'b0, 8'd27,  8'd157, 24'h800000, 27'h0000001};
      v[3] = '{8'd135, 8'd130, 24'h800000, 24'h800003, 1'b0, 8'd5,   8'd135, 24'h800000, 27'h0200001};
      v[4] = '{8'd130, 8'd170, 24'h800001, 24'h800000, 1'b1, 8'd40,  8'd170, 24'h800000, 27'h0000001};
      v[5] = '{8'd255, 8'd0,   24'hFFFFFF, 24'h800000, 1'b0, 8'd255, 8'd255, 24'hFFFFFF, 27'h0000001};
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(v[i].e1, v[i].e2, v[i].s1, v[i].s2);
         tick();
         in_valid = 1'b0;
         tick();
         checks++;
         if (out_valid !== 1'b1 || swap !== v[i].sw || shift !== v[i].sh || exp_big !== v[i].eb ||
             sig_big !== v[i].sb || sig_small !== v[i].ss) begin
            errors++;
            $display("FAIL shift_vec%0d got valid=%0b swap=%0b shift=%0d exp_big=%0d sig_big=%h sig_small=%h want 1/%0b/%0d/%0d/%h/%h",
                     i, out_valid, swap, shift, exp_big, sig_big, sig_small,
                     v[i].sw, v[i].sh, v[i].eb, v[i].sb, v[i].ss);
         end
      end
      tick();
   endtask

   task automatic test_backpressure;
      int   idx_in = 0;
      int   n_out = 0;
      logic acc;
      for (int cyc = 0; cyc < 24 && n_out < 4; cyc++) begin
         out_ready = (cyc >= 4);
         if (idx_in < 4) drive(8'(130 + idx_in), 8'd128, 24'h800000, 24'hC00000);
         else in_valid = 1'b0;
         #1;
         if (cyc < 4) begin
            checks++;
            if (in_ready !== (cyc < 2)) begin
               errors++; $display("FAIL bp_in_ready cycle%0d got=%0b want=%0b", cyc, in_ready, cyc < 2);
            end
         end
         if (cyc == 2 || cyc == 3) begin
            checks++;
            if (out_valid !== 1'b1 || exp_big !== 8'd130 || sig_small !== 27'h1800000) begin
               errors++;
               $display("FAIL bp_hold cycle%0d got valid=%0b exp_big=%0d sig_small=%h want 1/130/1800000",
                        cyc, out_valid, exp_big, sig_small);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_big !== 8'(130 + n_out) || sig_small !== (27'h6000000 >> (2 + n_out))) begin
               errors++;
               $display("FAIL bp_order result%0d got exp_big=%0d sig_small=%h want %0d/%h",
                        n_out, exp_big, sig_small, 130 + n_out, 27'h6000000 >> (2 + n_out));
            end
            n_out++;
         end
         acc = in_valid && in_ready;
         tick();
         if (acc) idx_in++;
      end
      in_valid = 1'b0;
      checks++;
      if (n_out != 4) begin
         errors++; $display("FAIL bp_count got=%0d want=4", n_out);
      end
      repeat (3) tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_duplicate got out_valid=%0b want=0", out_valid);
      end
   endtask

   task automatic test_reset_midflight;
      int stale = 0;
      out_ready = 1'b0;
      drive(8'd140, 8'd130, 24'h800000, 24'h800000);
      tick();
      drive(8'd141, 8'd130, 24'h800000, 24'h800000);
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL midrst_preload got out_valid=%0b want=1", out_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || exp_big !== 8'd0 || sig_small !== 27'd0) begin
         errors++;
         $display("FAIL midrst_async got valid=%0b exp_big=%0d sig_small=%h want 0/0/0",
                  out_valid, exp_big, sig_small);
      end
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (out_valid) stale++;
      end
      checks++;
      if (stale != 0) begin
         errors++; $display("FAIL midrst_stale got=%0d stale outputs want=0", stale);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL midrst_in_ready got=%0b want=1", in_ready);
      end
   endtask

   initial begin
      test_reset();
      test_direct();
      test_borrow();
      test_tie_back_to_back();
      test_shift_boundaries();
      test_backpressure();
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
